// File: rtl/map_table.sv
// Two-wide register alias table: speculative map with ready bits, retirement
// map, intra-group bypass, and restore-from-architectural-map on recover.
module map_table #(
    parameter int NUM_ARCH = 32,
    parameter int TAG_W    = 7
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       id_dispatch_num,
    input  logic [4:0]       id_ra_idx_0,
    input  logic [4:0]       id_rb_idx_0,
    input  logic [4:0]       id_dest_idx_0,
    input  logic [4:0]       id_ra_idx_1,
    input  logic [4:0]       id_rb_idx_1,
    input  logic [4:0]       id_dest_idx_1,
    input  logic [TAG_W-1:0] fl_pr0,
    input  logic [TAG_W-1:0] fl_pr1,
    input  logic             cdb_valid_0,
    input  logic             cdb_valid_1,
    input  logic [TAG_W-1:0] cdb_tag_0,
    input  logic [TAG_W-1:0] cdb_tag_1,
    input  logic [1:0]       rob_retire_num,
    input  logic [4:0]       rob_retire_dest_idx_0,
    input  logic [4:0]       rob_retire_dest_idx_1,
    input  logic [TAG_W-1:0] rob_retire_tag_0,
    input  logic [TAG_W-1:0] rob_retire_tag_1,
    input  logic             rob_recover,
    output logic [TAG_W-1:0] mt_ra_tag_0,
    output logic [TAG_W-1:0] mt_rb_tag_0,
    output logic [TAG_W-1:0] mt_ra_tag_1,
    output logic [TAG_W-1:0] mt_rb_tag_1,
    output logic             mt_ra_ready_0,
    output logic             mt_rb_ready_0,
    output logic             mt_ra_ready_1,
    output logic             mt_rb_ready_1,
    output logic [TAG_W-1:0] mt_old_tag_0,
    output logic [TAG_W-1:0] mt_old_tag_1
);
    localparam int         NUM_PHYS = 96;
    localparam logic [4:0] ZERO_IDX = 5'd31;

    logic [TAG_W-1:0]    spec_q [NUM_ARCH];
    logic [TAG_W-1:0]    spec_d [NUM_ARCH];
    logic [TAG_W-1:0]    arch_q [NUM_ARCH];
    logic [TAG_W-1:0]    arch_d [NUM_ARCH];
    logic [NUM_PHYS-1:0] ready_q;
    logic [NUM_PHYS-1:0] ready_d;

    logic slot0_act, slot1_act, d0_ren, d1_ren, ret0, ret1;
    logic byp_ra_1, byp_rb_1, same_dest;

    // A dispatch count of 3 behaves as 2; slot 1 is only ever active with slot 0.
    assign slot0_act = (id_dispatch_num != 2'd0);
    assign slot1_act = id_dispatch_num[1];
    assign d0_ren    = slot0_act && (id_dest_idx_0 != ZERO_IDX);
    assign d1_ren    = slot1_act && (id_dest_idx_1 != ZERO_IDX);
    assign ret0      = (rob_retire_num != 2'd0) && (rob_retire_dest_idx_0 != ZERO_IDX);
    assign ret1      = rob_retire_num[1] && (rob_retire_dest_idx_1 != ZERO_IDX);
    assign byp_ra_1  = slot1_act && d0_ren && (id_ra_idx_1 == id_dest_idx_0);
    assign byp_rb_1  = slot1_act && d0_ren && (id_rb_idx_1 == id_dest_idx_0);
    assign same_dest = slot1_act && d0_ren && (id_dest_idx_1 == id_dest_idx_0);

    function automatic logic in_range(input logic [TAG_W-1:0] t);
        return t < TAG_W'(NUM_PHYS);
    endfunction

    function automatic logic tag_ready(input logic [TAG_W-1:0] t);
        return (in_range(t) && ready_q[t]) ||
               (cdb_valid_0 && (cdb_tag_0 == t)) ||
               (cdb_valid_1 && (cdb_tag_1 == t));
    endfunction

    function automatic logic [TAG_W:0] lookup(input logic [4:0] idx, input logic byp);
        if (idx == ZERO_IDX)
            return {TAG_W'(ZERO_IDX), 1'b1};
        if (byp)
            return {fl_pr0, 1'b0};
        return {spec_q[idx], tag_ready(spec_q[idx])};
    endfunction

    always_comb begin
        {mt_ra_tag_0, mt_ra_ready_0} = lookup(id_ra_idx_0, 1'b0);
        {mt_rb_tag_0, mt_rb_ready_0} = lookup(id_rb_idx_0, 1'b0);
        {mt_ra_tag_1, mt_ra_ready_1} = lookup(id_ra_idx_1, byp_ra_1);
        {mt_rb_tag_1, mt_rb_ready_1} = lookup(id_rb_idx_1, byp_rb_1);
        mt_old_tag_0 = spec_q[id_dest_idx_0];
        mt_old_tag_1 = same_dest ? fl_pr0 : spec_q[id_dest_idx_1];
    end

    always_comb begin
        arch_d = arch_q;
        if (ret0) arch_d[rob_retire_dest_idx_0] = rob_retire_tag_0;
        if (ret1) arch_d[rob_retire_dest_idx_1] = rob_retire_tag_1;
    end

    // Dispatch clears are applied after CDB sets so a fresh allocation wins.
    always_comb begin
        spec_d  = spec_q;
        ready_d = ready_q;
        if (rob_recover) begin
            spec_d  = arch_d;
            ready_d = '1;
        end else begin
            if (cdb_valid_0 && in_range(cdb_tag_0)) ready_d[cdb_tag_0] = 1'b1;
            if (cdb_valid_1 && in_range(cdb_tag_1)) ready_d[cdb_tag_1] = 1'b1;
            if (d0_ren) spec_d[id_dest_idx_0] = fl_pr0;
            if (d1_ren) spec_d[id_dest_idx_1] = fl_pr1;
            if (slot0_act && in_range(fl_pr0)) ready_d[fl_pr0] = 1'b0;
            if (slot1_act && in_range(fl_pr1)) ready_d[fl_pr1] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ARCH; i++) begin
                spec_q[i] <= TAG_W'(i);
                arch_q[i] <= TAG_W'(i);
            end
            ready_q <= '1;
        end else begin
            spec_q  <= spec_d;
            arch_q  <= arch_d;
            ready_q <= ready_d;
        end
    end
endmodule

// File: tb/tb_map_table.sv
// Bench for map_table: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural rename model.
module tb_map_table;
    logic       clock = 1'b0;
    logic       reset_n;
    logic [1:0] id_dispatch_num;
    logic [4:0] id_ra_idx_0, id_rb_idx_0, id_dest_idx_0;
    logic [4:0] id_ra_idx_1, id_rb_idx_1, id_dest_idx_1;
    logic [6:0] fl_pr0, fl_pr1;
    logic       cdb_valid_0, cdb_valid_1;
    logic [6:0] cdb_tag_0, cdb_tag_1;
    logic [1:0] rob_retire_num;
    logic [4:0] rob_retire_dest_idx_0, rob_retire_dest_idx_1;
    logic [6:0] rob_retire_tag_0, rob_retire_tag_1;
    logic       rob_recover;
    logic [6:0] mt_ra_tag_0, mt_rb_tag_0, mt_ra_tag_1, mt_rb_tag_1;
    logic       mt_ra_ready_0, mt_rb_ready_0, mt_ra_ready_1, mt_rb_ready_1;
    logic [6:0] mt_old_tag_0, mt_old_tag_1;

    map_table dut (
        .clock(clock), .reset_n(reset_n), .id_dispatch_num(id_dispatch_num),
        .id_ra_idx_0(id_ra_idx_0), .id_rb_idx_0(id_rb_idx_0), .id_dest_idx_0(id_dest_idx_0),
        .id_ra_idx_1(id_ra_idx_1), .id_rb_idx_1(id_rb_idx_1), .id_dest_idx_1(id_dest_idx_1),
        .fl_pr0(fl_pr0), .fl_pr1(fl_pr1),
        .cdb_valid_0(cdb_valid_0), .cdb_valid_1(cdb_valid_1),
        .cdb_tag_0(cdb_tag_0), .cdb_tag_1(cdb_tag_1),
        .rob_retire_num(rob_retire_num),
        .rob_retire_dest_idx_0(rob_retire_dest_idx_0), .rob_retire_dest_idx_1(rob_retire_dest_idx_1),
        .rob_retire_tag_0(rob_retire_tag_0), .rob_retire_tag_1(rob_retire_tag_1),
        .rob_recover(rob_recover),
        .mt_ra_tag_0(mt_ra_tag_0), .mt_rb_tag_0(mt_rb_tag_0),
        .mt_ra_tag_1(mt_ra_tag_1), .mt_rb_tag_1(mt_rb_tag_1),
        .mt_ra_ready_0(mt_ra_ready_0), .mt_rb_ready_0(mt_rb_ready_0),
        .mt_ra_ready_1(mt_ra_ready_1), .mt_rb_ready_1(mt_rb_ready_1),
        .mt_old_tag_0(mt_old_tag_0), .mt_old_tag_1(mt_old_tag_1)
    );

    always #5 clock = ~clock;

    int nerr = 0;
    int nchk = 0;

    // Behavioural model: plain arrays of integers
    int m_spec [32];
    int m_arch [32];
    int m_rdy  [96];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_spec[i] = i;
            m_arch[i] = i;
        end
        for (int i = 0; i < 96; i++) m_rdy[i] = 1;
    endtask

    function automatic int clamp2(input logic [1:0] v);
        return (v == 2'd3) ? 2 : int'(v);
    endfunction

    task automatic model_step();
        int n, rn, d, f;
        n  = clamp2(id_dispatch_num);
        rn = clamp2(rob_retire_num);
        for (int k = 0; k < rn; k++) begin
            d = (k == 0) ? int'(rob_retire_dest_idx_0) : int'(rob_retire_dest_idx_1);
            f = (k == 0) ? int'(rob_retire_tag_0) : int'(rob_retire_tag_1);
            if (d != 31) m_arch[d] = f;
        end
        if (rob_recover) begin
            for (int i = 0; i < 32; i++) m_spec[i] = m_arch[i];
            for (int i = 0; i < 96; i++) m_rdy[i] = 1;
            return;
        end
        if (cdb_valid_0) m_rdy[cdb_tag_0] = 1;
        if (cdb_valid_1) m_rdy[cdb_tag_1] = 1;
        for (int k = 0; k < n; k++) begin
            d = (k == 0) ? int'(id_dest_idx_0) : int'(id_dest_idx_1);
            f = (k == 0) ? int'(fl_pr0) : int'(fl_pr1);
            if (d != 31) m_spec[d] = f;
            m_rdy[f] = 0;
        end
    endtask

    task automatic exp_src(input int slot, input int idx, output int t, output int r);
        int n;
        n = clamp2(id_dispatch_num);
        if (idx == 31) begin
            t = 31; r = 1;
        end else if (slot == 1 && n == 2 && id_dest_idx_0 != 5'd31 && idx == int'(id_dest_idx_0)) begin
            t = fl_pr0; r = 0;
        end else begin
            t = m_spec[idx];
            r = (m_rdy[t] == 1) || (cdb_valid_0 && int'(cdb_tag_0) == t) ||
                (cdb_valid_1 && int'(cdb_tag_1) == t);
        end
    endtask

    task automatic check_model();
        int t, r, o1, n;
        n = clamp2(id_dispatch_num);
        exp_src(0, id_ra_idx_0, t, r); chk("ra_tag_0", mt_ra_tag_0, t); chk("ra_ready_0", mt_ra_ready_0, r);
        exp_src(0, id_rb_idx_0, t, r); chk("rb_tag_0", mt_rb_tag_0, t); chk("rb_ready_0", mt_rb_ready_0, r);
        exp_src(1, id_ra_idx_1, t, r); chk("ra_tag_1", mt_ra_tag_1, t); chk("ra_ready_1", mt_ra_ready_1, r);
        exp_src(1, id_rb_idx_1, t, r); chk("rb_tag_1", mt_rb_tag_1, t); chk("rb_ready_1", mt_rb_ready_1, r);
        chk("old_tag_0", mt_old_tag_0, m_spec[id_dest_idx_0]);
        o1 = (n == 2 && id_dest_idx_0 != 5'd31 && id_dest_idx_1 == id_dest_idx_0) ? int'(fl_pr0)
                                                                                    : m_spec[id_dest_idx_1];
        chk("old_tag_1", mt_old_tag_1, o1);
    endtask

    task automatic settle_check();
        @(negedge clock);
        check_model();
    endtask

    task automatic tick();
        @(posedge clock);
        if (reset_n) model_step();
        else model_reset();
        #1;
    endtask

    task automatic clear_inputs();
        id_dispatch_num = 0;
        id_ra_idx_0 = 0; id_rb_idx_0 = 0; id_dest_idx_0 = 0;
        id_ra_idx_1 = 0; id_rb_idx_1 = 0; id_dest_idx_1 = 0;
        fl_pr0 = 0; fl_pr1 = 0;
        cdb_valid_0 = 0; cdb_valid_1 = 0; cdb_tag_0 = 0; cdb_tag_1 = 0;
        rob_retire_num = 0; rob_retire_dest_idx_0 = 0; rob_retire_dest_idx_1 = 0;
        rob_retire_tag_0 = 0; rob_retire_tag_1 = 0;
        rob_recover = 0;
    endtask

    function automatic logic [4:0] rnd_idx();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 5'd31;
        if (r < 6) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        reset_n = 1'b0;
        clear_inputs();
        model_reset();

        // Reset state with all inputs zero
        settle_check();
        chk("rst_ra_tag_0", mt_ra_tag_0, 0);
        chk("rst_ra_ready_1", mt_ra_ready_1, 1);
        chk("rst_old_tag_1", mt_old_tag_1, 0);
        tick();
        reset_n = 1'b1;

        // Plain lookup
        id_ra_idx_0 = 5; id_rb_idx_0 = 31; id_dest_idx_0 = 7;
        settle_check();
        chk("lk_ra_tag", mt_ra_tag_0, 5);
        chk("lk_rb_tag", mt_rb_tag_0, 31);
        chk("lk_ra_rdy", mt_ra_ready_0, 1);
        chk("lk_rb_rdy", mt_rb_ready_0, 1);
        chk("lk_old", mt_old_tag_0, 7);
        tick();

        // Two-wide dispatch with intra-group dependency and same destination
        clear_inputs();
        id_dispatch_num = 2; id_dest_idx_0 = 3; fl_pr0 = 32;
        id_ra_idx_1 = 3; id_dest_idx_1 = 3; fl_pr1 = 33;
        settle_check();
        chk("grp_ra_tag_1", mt_ra_tag_1, 32);
        chk("grp_ra_rdy_1", mt_ra_ready_1, 0);
        chk("grp_old_0", mt_old_tag_0, 3);
        chk("grp_old_1", mt_old_tag_1, 32);
        tick();
        clear_inputs();
        id_ra_idx_0 = 3;
        settle_check();
        chk("grp_next_tag", mt_ra_tag_0, 33);
        chk("grp_next_rdy", mt_ra_ready_0, 0);
        tick();

        // CDB bypass in the lookup cycle, then persistent
        cdb_valid_0 = 1; cdb_tag_0 = 33;
        settle_check();
        chk("cdb_byp_rdy", mt_ra_ready_0, 1);
        tick();
        cdb_valid_0 = 0; cdb_tag_0 = 0;
        settle_check();
        chk("cdb_held_rdy", mt_ra_ready_0, 1);
        tick();

        // Dispatch clear beats same-cycle CDB set
        clear_inputs();
        id_dispatch_num = 1; id_dest_idx_0 = 4; fl_pr0 = 40;
        cdb_valid_1 = 1; cdb_tag_1 = 40;
        settle_check();
        tick();
        clear_inputs();
        id_ra_idx_0 = 4;
        settle_check();
        chk("clr_win_tag", mt_ra_tag_0, 40);
        chk("clr_win_rdy", mt_ra_ready_0, 0);
        tick();

        // Recover with a same-cycle retirement
        clear_inputs();
        id_dispatch_num = 2; id_dest_idx_0 = 1; fl_pr0 = 50; id_dest_idx_1 = 2; fl_pr1 = 51;
        settle_check();
        tick();
        clear_inputs();
        rob_retire_num = 1; rob_retire_dest_idx_0 = 1; rob_retire_tag_0 = 50; rob_recover = 1;
        id_ra_idx_0 = 1;
        settle_check();
        chk("rec_pre_tag", mt_ra_tag_0, 50);
        chk("rec_pre_rdy", mt_ra_ready_0, 0);
        tick();
        clear_inputs();
        id_ra_idx_0 = 1; id_rb_idx_0 = 2; id_ra_idx_1 = 3; id_rb_idx_1 = 4;
        settle_check();
        chk("rec_r1_tag", mt_ra_tag_0, 50);
        chk("rec_r1_rdy", mt_ra_ready_0, 1);
        chk("rec_r2_tag", mt_rb_tag_0, 2);
        chk("rec_r3_tag", mt_ra_tag_1, 3);
        chk("rec_r4_rdy", mt_rb_ready_1, 1);
        tick();

        // Zero register destination
        clear_inputs();
        id_dispatch_num = 1; id_dest_idx_0 = 31; fl_pr0 = 60;
        settle_check();
        chk("zr_old", mt_old_tag_0, 31);
        tick();
        clear_inputs();
        id_ra_idx_0 = 31; id_dispatch_num = 1; id_dest_idx_0 = 5; fl_pr0 = 70;
        settle_check();
        chk("zr_tag", mt_ra_tag_0, 31);
        chk("zr_rdy", mt_ra_ready_0, 1);
        tick();

        // Asynchronous reset mid-cycle
        clear_inputs();
        id_ra_idx_0 = 5;
        #1;
        chk("pre_rst_tag", mt_ra_tag_0, 70);
        reset_n = 1'b0;
        model_reset();
        #1;
        check_model();
        chk("async_rst_tag", mt_ra_tag_0, 5);
        chk("async_rst_rdy", mt_ra_ready_0, 1);
        tick();
        reset_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            id_dispatch_num = 2'($urandom_range(0, 3));
            id_ra_idx_0 = rnd_idx(); id_rb_idx_0 = rnd_idx(); id_dest_idx_0 = rnd_idx();
            id_ra_idx_1 = rnd_idx(); id_rb_idx_1 = rnd_idx(); id_dest_idx_1 = rnd_idx();
            fl_pr0 = 7'($urandom_range(32, 95));
            fl_pr1 = 7'($urandom_range(32, 95));
            cdb_valid_0 = 1'($urandom_range(0, 1));
            cdb_valid_1 = 1'($urandom_range(0, 1));
            cdb_tag_0 = $urandom_range(0, 1) ? 7'(m_spec[$urandom_range(0, 31)]) : 7'($urandom_range(0, 95));
            cdb_tag_1 = $urandom_range(0, 1) ? 7'(m_spec[$urandom_range(0, 31)]) : 7'($urandom_range(0, 95));
            rob_retire_num = 2'($urandom_range(0, 3));
            rob_retire_dest_idx_0 = rnd_idx(); rob_retire_dest_idx_1 = rnd_idx();
            rob_retire_tag_0 = 7'($urandom_range(0, 95));
            rob_retire_tag_1 = 7'($urandom_range(0, 95));
            rob_recover = ($urandom_range(0, 15) == 0);
            settle_check();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
